mul_rr_scheduler: RTL and testbench

// Shares one pipelined signed/unsigned N-bit multiplier between N_REQ requesters.
// - Each requester presents a, b and a sign bit with valid/ready.
// - A round-robin arbiter grants one request per cycle into the pipeline.
// - Products return on a single result port tagged with the requester index.
// - Sits between several datapath clients and the one multiplier resource they share.
//

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/mul_pipe.sv | 111 +++++++++++
 rtl/mul_rr_scheduler.sv | 105 ++++++++++
 tb/tb_mul_rr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Holds the default sizing and the id-width rule used by the top and the pipeline.
package mul_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_LAT   = 2;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } sign_mode_e;

  // Requester index width; a lone requester still needs one id bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// LAT-stage signed/unsigned W x W -> 2W multiplier with a global advance enable.
// Valid and requester id travel alongside the data; data only loads behind a valid.
module mul_pipe
  import mul_sched_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int LAT  = DEF_LAT,
  parameter int ID_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              in_valid_i,
  input  logic              in_sign_i,
  input  logic [ID_W-1:0]   in_id_i,
  input  logic [W-1:0]      in_a_i,
  input  logic [W-1:0]      in_b_i,
  output logic              out_valid_o,
  output logic [ID_W-1:0]   out_id_o,
  output logic [2*W-1:0]    out_p_o
);

  typedef struct packed {
    logic            valid;
    logic            sign;
    logic [ID_W-1:0] id;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
  } op_stage_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [2*W-1:0]  p;
  } prod_stage_t;

  // Extending both operands to 2W makes the truncated 2W product exact for either mode.
  function automatic logic [2*W-1:0] mul_ext(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input sign_mode_e mode);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = (mode == MODE_SIGNED) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = (mode == MODE_SIGNED) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  generate
    if (LAT == 1) begin : g_single
      prod_stage_t out_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else if (en_i) begin
          out_q.valid <= in_valid_i;
          if (in_valid_i) begin
            out_q.id <= in_id_i;
            out_q.p  <= mul_ext(in_a_i, in_b_i, sign_mode_e'(in_sign_i));
          end
        end
      end

      assign out_valid_o = out_q.valid;
      assign out_id_o    = out_q.id;
      assign out_p_o     = out_q.p;
    end else begin : g_multi
      localparam int NP = LAT - 1;

      op_stage_t   op_q;
      prod_stage_t prod_q [NP];

      // NOTE: data fields are reset along with the valids so res/res_id read 0 after
      // reset rather than whatever operands were in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          op_q <= '0;
          for (int j = 0; j < NP; j++) prod_q[j] <= '0;
        end else if (en_i) begin
          // NOTE: non-blocking assignments let every stage read last cycle's value of
          // the stage before it, which is what makes this a shift rather than a wire.
          op_q.valid <= in_valid_i;
          if (in_valid_i) begin
            op_q.sign <= in_sign_i;
            op_q.id   <= in_id_i;
            op_q.a    <= in_a_i;
            op_q.b    <= in_b_i;
          end

          prod_q[0].valid <= op_q.valid;
          if (op_q.valid) begin
            prod_q[0].id <= op_q.id;
            prod_q[0].p  <= mul_ext(op_q.a, op_q.b, sign_mode_e'(op_q.sign));
          end

          for (int j = 1; j < NP; j++) begin
            prod_q[j].valid <= prod_q[j-1].valid;
            if (prod_q[j-1].valid) begin
              prod_q[j].id <= prod_q[j-1].id;
              prod_q[j].p  <= prod_q[j-1].p;
            end
          end
        end
      end

      assign out_valid_o = prod_q[NP-1].valid;
      assign out_id_o    = prod_q[NP-1].id;
      assign out_p_o     = prod_q[NP-1].p;
    end
  endgenerate

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one pipelined multiplier among N_REQ requesters.
// One grant per unstalled cycle; results return in acceptance order tagged with the id.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  parameter  int LAT   = DEF_LAT,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic [N_REQ-1:0]     req_sign,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*W-1:0]       res,
  output logic [ID_W-1:0]      res_id
);

  localparam int SW = ID_W + 1;

  logic            stall;
  logic            accept;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [SW-1:0]   cand_sum;
  logic [ID_W-1:0] cand;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_sign;

  // A held result blocks the whole pipe; an empty output slot never does.
  assign stall = res_valid & ~res_ready;

  // Search upward from the pointer with wrap-around; first valid requester wins.
  // NOTE: every always_comb output is given a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + SW'(k);
      if (cand_sum >= SW'(N_REQ)) cand_sum = cand_sum - SW'(N_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = grant_found & ~stall & ~rst;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_sign  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*W +: W];
        sel_b        = req_b[i*W +: W];
        sel_sign     = req_sign[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  mul_pipe #(
    .W    (W),
    .LAT  (LAT),
    .ID_W (ID_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .en_i        (~stall),
    .in_valid_i  (accept),
    .in_sign_i   (sel_sign),
    .in_id_i     (grant_idx),
    .in_a_i      (sel_a),
    .in_b_i      (sel_b),
    .out_valid_o (res_valid),
    .out_id_o    (res_id),
    .out_p_o     (res)
  );

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Scoreboard bench for mul_rr_scheduler: reference arbiter and arithmetic model push
// expected results on each handshake; a separate monitor pops them as results leave.
module tb_mul_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int LAT   = 2;
  localparam int ID_W  = 2;
  localparam int PW    = 2 * W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*W-1:0]   req_a;
  logic [N_REQ*W-1:0]   req_b;
  logic [N_REQ-1:0]     req_sign;
  logic                 res_valid;
  logic                 res_ready;
  logic [PW-1:0]        res;
  logic [ID_W-1:0]      res_id;

  always #5 clk = ~clk;

  mul_rr_scheduler #(.N_REQ(N_REQ), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sign  (req_sign),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .res_id    (res_id)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [PW-1:0]   p;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   m_ptr  = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden product from plain integer arithmetic on the operand values.
  function automatic logic [PW-1:0] ref_mul(input int a, input int b, input bit sgn);
    int x;
    int y;
    x = a;
    y = b;
    if (sgn) begin
      if (x >= 2 ** (W - 1)) x -= 2 ** W;
      if (y >= 2 ** (W - 1)) y -= 2 ** W;
    end
    return PW'(x * y);
  endfunction

  // Reference arbiter: predicts req_ready, logs grants, pushes expected results.
  always @(negedge clk) begin : model
    logic             stall_now;
    logic [N_REQ-1:0] exp_rdy;
    int               g;
    int               idx;
    exp_t             e;
    stall_now = res_valid && !res_ready;
    exp_rdy   = '0;
    g         = -1;
    if (!rst && !stall_now) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
    if (rst) begin
      m_ptr = 0;
      sb.delete();
    end else if (g >= 0) begin
      e.id = ID_W'(g);
      e.p  = ref_mul(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), req_sign[g]);
      sb.push_back(e);
      m_ptr = (g + 1) % N_REQ;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(res), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_res", 32'(res), 32'(e.p));
        check("sb_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b, input bit s);
    req_valid[i]      = v;
    req_a[i*W +: W]   = W'(a);
    req_b[i*W +: W]   = W'(b);
    req_sign[i]       = s;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
      req_sign[i]     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    res_ready = 1'b1;
    for (int t = 0; t < 8 * LAT + 10 && sb.size() != 0; t++) tick();
    repeat (3) tick();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r;
    bit acc;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    res_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res", 32'(res), 0);
    check("rst_res_id", 32'(res_id), 0);
    tick();
    rst = 1'b0;

    // Signed request from requester 2 alone.
    set_req(2, 1, 4'hD, 4'h3, 1);
    @(negedge clk);
    check("t1_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_not_early", 32'(res_valid), 0);
    tick();
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 1);
    check("t1_res", 32'(res), 32'hF7);
    check("t1_id", 32'(res_id), 2);
    tick();

    // Unsigned request from requester 1; pointer sits at 3.
    set_req(1, 1, 4'hF, 4'hF, 0);
    @(negedge clk);
    check("t2_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t2_not_early", 32'(res_valid), 0);
    check("t2_hold_res", 32'(res), 32'hF7);
    check("t2_hold_id", 32'(res_id), 2);
    tick();
    @(negedge clk);
    check("t2_valid", 32'(res_valid), 1);
    check("t2_res", 32'(res), 32'hE1);
    check("t2_id", 32'(res_id), 1);
    tick();

    // Requester 3 alone moves the pointer back to 0.
    set_req(3, 1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    @(negedge clk);
    check("t3_pre_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;

    // Round robin with all four held valid.
    grant_log.delete();
    req_valid = '1;
    randomize_ops();
    for (int i = 0; i < 8; i++) begin
      tick();
      randomize_ops();
    end
    for (int i = 0; i < 8; i++)
      check("rr_order", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hFF, 32'(i % N_REQ));

    // Backpressure with the pipeline full.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 0);
      check("bp_valid", 32'(res_valid), 1);
      check("bp_res", 32'(res), (sb.size() > 0) ? 32'(sb[0].p) : 32'hFFFF);
      check("bp_id", 32'(res_id), (sb.size() > 0) ? 32'(sb[0].id) : 32'hFF);
      tick();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      randomize_ops();
    end
    drain("bp_drain");

    // Reset with products in flight.
    req_valid = '1;
    randomize_ops();
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_res_valid", 32'(res_valid), 0);
    check("t5_res", 32'(res), 0);
    check("t5_res_id", 32'(res_id), 0);
    check("t5_first_grant", 32'(req_ready), 32'b0001);
    tick();
    drain("t5_drain");

    // Exhaustive operand sweep through random requesters under random contention.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          r   = $urandom_range(0, N_REQ - 1);
          acc = 1'b0;
          for (int t = 0; t < 64 && !acc; t++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++) begin
              if (i != r)
                set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                        $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end
            set_req(r, 1, a, b, 1'(s));
            @(negedge clk);
            acc = req_ready[r];
            tick();
          end
          if (!acc) check("sweep_accept", 0, 1);
        end
      end
    end
    drain("sweep_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
